// File: rtl/uart_dump_if.sv
// Purpose: bundles the control, RAM read-port and UART TX byte signals of the
// RAM dump engine.
// Modports:
//   master - the dump engine (drives status, RAM read strobe/address, TX byte)
//   slave  - the surrounding system (drives start/base/len, RAM data, TX ready)
interface uart_dump_if #(
  parameter int unsigned ADDR_LEN = 14,
  parameter int unsigned XLEN     = 32
);
  logic                dump_start;
  logic [ADDR_LEN-1:0] dump_base_addr;
  logic [ADDR_LEN-1:0] dump_len;
  logic                during_dump;
  logic                dump_done;
  logic                uart_ram_rd_en;
  logic [ADDR_LEN-1:0] uart_ram_addr;
  logic [XLEN-1:0]     uart_ram_rd_data;
  logic                uart_tx_valid;
  logic [7:0]          uart_tx_data;
  logic                uart_tx_ready;

  modport master (
    input  dump_start, dump_base_addr, dump_len, uart_ram_rd_data, uart_tx_ready,
    output during_dump, dump_done, uart_ram_rd_en, uart_ram_addr,
           uart_tx_valid, uart_tx_data
  );

  modport slave (
    output dump_start, dump_base_addr, dump_len, uart_ram_rd_data, uart_tx_ready,
    input  during_dump, dump_done, uart_ram_rd_en, uart_ram_addr,
           uart_tx_valid, uart_tx_data
  );
endinterface

// File: rtl/uart_dump.sv
// Purpose: reads a block of RAM words and streams each word out to the UART
// transmitter byte by byte, least-significant byte first.
// Ports:
//   clk  - system clock
//   rstb - asynchronous active-low reset
//   bus  - uart_dump_if.master: start/base/len in, during_dump/dump_done out,
//          RAM read strobe/address out and read data in, TX valid/data out
//          and TX ready in. All outputs are registered.
module uart_dump #(
  parameter int unsigned ADDR_LEN = 14,
  parameter int unsigned XLEN     = 32
) (
  input  logic        clk,
  input  logic        rstb,
  uart_dump_if.master bus
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_LEN-1:0] r_word_addr;
  logic [ADDR_LEN-1:0] r_remain;
  logic [XLEN-1:0]     r_shift;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic                r_during;
  logic                r_done;
  logic                r_rd_en;
  logic [ADDR_LEN-1:0] r_ram_addr;
  logic                r_tx_valid;
  logic [7:0]          r_tx_data;

  logic [XLEN-1:0]     w_shift_nxt;
  logic [ADDR_LEN-1:0] w_addr_nxt;
  logic [ADDR_LEN-1:0] w_remain_nxt;
  logic                w_last_byte;

  assign w_shift_nxt  = r_shift >> 8;
  assign w_addr_nxt   = r_word_addr + ADDR_LEN'(1);  // wraps modulo 2^ADDR_LEN
  assign w_remain_nxt = r_remain - ADDR_LEN'(1);
  assign w_last_byte  = (r_byte_cnt == CNT_W'(NB - 1));

  // Sequencer: outputs are loaded on the edge that enters the state they
  // belong to, so every output is a flop and matches the current state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_word_addr <= '0;
      r_remain    <= '0;
      r_shift     <= '0;
      r_byte_cnt  <= '0;
      r_during    <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_ram_addr  <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.dump_start) begin
            r_word_addr <= bus.dump_base_addr;
            r_remain    <= bus.dump_len;
            r_during    <= 1'b1;
            if (bus.dump_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_READ;
              r_rd_en    <= 1'b1;
              r_ram_addr <= bus.dump_base_addr;
            end
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // RAM data is valid this cycle; byte lane 0 goes out first
          r_shift    <= bus.uart_ram_rd_data;
          r_byte_cnt <= '0;
          r_tx_valid <= 1'b1;
          r_tx_data  <= bus.uart_ram_rd_data[7:0];
          r_state    <= S_SEND;
        end
        S_SEND: begin
          // valid is always high here, so ready alone marks a handshake
          if (bus.uart_tx_ready) begin
            r_shift    <= w_shift_nxt;
            r_tx_data  <= w_shift_nxt[7:0];
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            if (w_last_byte) begin
              r_tx_valid  <= 1'b0;
              r_word_addr <= w_addr_nxt;
              r_remain    <= w_remain_nxt;
              if (w_remain_nxt != '0) begin
                r_state    <= S_READ;
                r_rd_en    <= 1'b1;
                r_ram_addr <= w_addr_nxt;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_during <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_during   <= 1'b0;
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.during_dump    = r_during;
  assign bus.dump_done      = r_done;
  assign bus.uart_ram_rd_en = r_rd_en;
  assign bus.uart_ram_addr  = r_ram_addr;
  assign bus.uart_tx_valid  = r_tx_valid;
  assign bus.uart_tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_dump.sv
// Bench for uart_dump: a RAM model answers reads, a queue-based reference
// predicts the address sequence and the little-endian byte stream, and a
// negedge monitor checks every read, handshake, stall and done pulse.
module tb_uart_dump;

  localparam int unsigned ADDR_LEN = 14;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NB       = XLEN / 8;
  localparam int unsigned DEPTH    = 1 << ADDR_LEN;

  logic clk  = 1'b0;
  logic rstb = 1'b1;

  uart_dump_if #(.ADDR_LEN(ADDR_LEN), .XLEN(XLEN)) bus ();

  uart_dump #(.ADDR_LEN(ADDR_LEN), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency
  logic [XLEN-1:0] ram [DEPTH];
  always @(posedge clk)
    if (bus.uart_ram_rd_en) bus.uart_ram_rd_data <= ram[bus.uart_ram_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference expectations
  logic [ADDR_LEN-1:0] exp_addr [$];
  logic [7:0]          exp_byte [$];
  logic [7:0]          got_byte [$];

  task automatic model_load(input int base, input int len);
    logic [ADDR_LEN-1:0] a;
    logic [XLEN-1:0]     word;
    for (int w = 0; w < len; w++) begin
      a = ADDR_LEN'(base + w);
      exp_addr.push_back(a);
      word = ram[a];
      for (int b = 0; b < int'(NB); b++) exp_byte.push_back(8'(word >> (8 * b)));
    end
  endtask

  // Monitor statistics
  int   cyc = 0;
  int   n_rd, n_valid, n_done, n_during;
  int   t_start, t_rd, t_val, t_done;
  logic prev_stall = 1'b0;
  logic prev_done  = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic clear_stats();
    n_rd = 0; n_valid = 0; n_done = 0; n_during = 0;
    t_start = -1; t_rd = -1; t_val = -1; t_done = -1;
    exp_addr.delete(); exp_byte.delete(); got_byte.delete();
  endtask

  // TX ready: always high (mode 0) or high one cycle in three (mode 1)
  int rmode = 0;
  always @(posedge clk) begin
    #2;
    bus.uart_tx_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rstb) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (bus.dump_start && !bus.during_dump && t_start < 0) t_start = cyc;
      if (bus.uart_ram_rd_en) begin
        n_rd++;
        if (t_rd < 0) t_rd = cyc;
        chk("rd_expected", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0)
          chk("rd_addr", 32'(bus.uart_ram_addr), 32'(exp_addr.pop_front()));
      end
      if (bus.uart_tx_valid) begin
        n_valid++;
        if (t_val < 0) t_val = cyc;
      end
      if (bus.uart_tx_valid && bus.uart_tx_ready) begin
        got_byte.push_back(bus.uart_tx_data);
        chk("tx_expected", 32'(exp_byte.size() != 0), 32'd1);
        if (exp_byte.size() != 0)
          chk("tx_byte", 32'(bus.uart_tx_data), 32'(exp_byte.pop_front()));
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.uart_tx_valid), 32'd1);
        chk("stall_data", 32'(bus.uart_tx_data), 32'(prev_data));
      end
      if (prev_done) chk("during_after_done", 32'(bus.during_dump), 32'd0);
      if (bus.dump_done) begin
        n_done++;
        t_done = cyc;
        chk("during_at_done", 32'(bus.during_dump), 32'd1);
      end
      if (bus.during_dump) n_during++;
      prev_stall = bus.uart_tx_valid && !bus.uart_tx_ready;
      prev_data  = bus.uart_tx_data;
      prev_done  = bus.dump_done;
    end
  end

  task automatic start(input int base, input int len);
    @(posedge clk); #2;
    bus.dump_start     = 1'b1;
    bus.dump_base_addr = ADDR_LEN'(base);
    bus.dump_len       = ADDR_LEN'(len);
    @(posedge clk); #2;
    bus.dump_start     = 1'b0;
    bus.dump_base_addr = ADDR_LEN'(14'h1234);  // later changes must be ignored
    bus.dump_len       = ADDR_LEN'(7);
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (n_done == 0 && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", 32'(n_done != 0), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic end_checks();
    chk("addr_left", 32'(exp_addr.size()), 32'd0);
    chk("bytes_left", 32'(exp_byte.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_during"}, 32'(bus.during_dump), 32'd0);
    chk({tag, "_done"},   32'(bus.dump_done), 32'd0);
    chk({tag, "_rd_en"},  32'(bus.uart_ram_rd_en), 32'd0);
    chk({tag, "_addr"},   32'(bus.uart_ram_addr), 32'd0);
    chk({tag, "_valid"},  32'(bus.uart_tx_valid), 32'd0);
    chk({tag, "_data"},   32'(bus.uart_tx_data), 32'd0);
  endtask

  initial begin
    int k;
    bus.dump_start     = 1'b0;
    bus.dump_base_addr = '0;
    bus.dump_len       = '0;
    for (int i = 0; i < int'(DEPTH); i++)
      ram[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    ram[5]     = 32'h4433_2211;
    ram[0]     = 32'h0302_0100;
    ram[1]     = 32'h0706_0504;
    ram[2]     = 32'h0B0A_0908;
    ram[14'h3FFF] = 32'hDDCC_BBAA;
    clear_stats();

    // Reset state
    #1 rstb = 1'b0;
    #10 check_all_zero("reset");
    #11 rstb = 1'b1;

    // Single word, ready tied high
    rmode = 0;
    clear_stats();
    model_load(5, 1);
    start(5, 1);
    wait_done(100);
    end_checks();
    chk("t1_nbytes", 32'(got_byte.size()), 32'd4);
    if (got_byte.size() == 4) begin
      chk("t1_b0", 32'(got_byte[0]), 32'h11);
      chk("t1_b1", 32'(got_byte[1]), 32'h22);
      chk("t1_b2", 32'(got_byte[2]), 32'h33);
      chk("t1_b3", 32'(got_byte[3]), 32'h44);
    end
    chk("t1_nrd", 32'(n_rd), 32'd1);
    chk("t1_rd_lat", 32'(t_rd - t_start), 32'd1);
    chk("t1_val_lat", 32'(t_val - t_start), 32'd3);
    chk("t1_done_lat", 32'(t_done - t_start), 32'd7);
    chk("t1_nvalid", 32'(n_valid), 32'd4);

    // Multi-word with backpressure
    rmode = 1;
    clear_stats();
    model_load(0, 3);
    start(0, 3);
    wait_done(400);
    end_checks();
    chk("t2_nrd", 32'(n_rd), 32'd3);
    chk("t2_nbytes", 32'(got_byte.size()), 32'd12);
    for (int i = 0; i < got_byte.size() && i < 12; i++)
      chk("t2_order", 32'(got_byte[i]), 32'(i));

    // Zero length
    rmode = 0;
    clear_stats();
    start(9, 0);
    wait_done(20);
    chk("t3_ndone", 32'(n_done), 32'd1);
    chk("t3_nduring", 32'(n_during), 32'd1);
    chk("t3_nrd", 32'(n_rd), 32'd0);
    chk("t3_nvalid", 32'(n_valid), 32'd0);
    chk("t3_done_lat", 32'(t_done - t_start), 32'd1);

    // Address wrap
    clear_stats();
    model_load(14'h3FFF, 2);
    start(14'h3FFF, 2);
    wait_done(100);
    end_checks();
    chk("t4_nrd", 32'(n_rd), 32'd2);
    chk("t4_nbytes", 32'(got_byte.size()), 32'd8);
    if (got_byte.size() == 8) begin
      chk("t4_b0", 32'(got_byte[0]), 32'hAA);
      chk("t4_b3", 32'(got_byte[3]), 32'hDD);
      chk("t4_b4", 32'(got_byte[4]), 32'h00);
      chk("t4_b7", 32'(got_byte[7]), 32'h03);
    end
    chk("t4_done_lat", 32'(t_done - t_start), 32'd13);

    // Start while busy is ignored
    clear_stats();
    model_load(20, 2);
    start(20, 2);
    repeat (3) @(posedge clk);
    start(100, 5);
    wait_done(100);
    end_checks();
    chk("t5_nrd", 32'(n_rd), 32'd2);
    chk("t5_nbytes", 32'(got_byte.size()), 32'd8);
    chk("t5_done_lat", 32'(t_done - t_start), 32'd13);

    // Reset while byte 2 of word 1 is on the bus
    clear_stats();
    model_load(40, 3);
    start(40, 3);
    k = 0;
    while (got_byte.size() < 6 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("t6_reached", 32'(got_byte.size()), 32'd6);
    #3 rstb = 1'b0;
    #1 check_all_zero("t6_rst");
    repeat (3) @(posedge clk);
    chk("t6_no_done", 32'(n_done), 32'd0);
    #2 rstb = 1'b1;
    clear_stats();
    model_load(40, 3);
    start(40, 3);
    wait_done(100);
    end_checks();
    chk("t6_nbytes", 32'(got_byte.size()), 32'd12);
    chk("t6_nrd", 32'(n_rd), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
